// File: rtl/xif_mac_coproc.sv
// X-interface coprocessor with a 32-bit accumulator: MAC (byte-serial multiply, 4 cycles), CLR and RDACC.
// Each instruction is held until the core commits or kills it, then its result is offered on the result port.
module xif_mac_coproc #(
  parameter int         X_ID_WIDTH = 4,
  parameter logic [6:0] OPCODE     = 7'h0B
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]           issue_rs1_i,
  input  logic [31:0]           issue_rs2_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_t;

  localparam logic [2:0] F3_MAC = 3'd0;
  localparam logic [2:0] F3_CLR = 3'd1;

  state_t                  state_reg;
  logic [31:0]             acc_reg;
  logic [31:0]             rs1_reg;
  logic [31:0]             rs2_reg;
  logic [31:0]             prod_reg;
  logic [X_ID_WIDTH-1:0]   id_reg;
  logic [4:0]              rd_reg;
  logic [2:0]              funct3_reg;
  logic [1:0]              mac_cnt_reg;
  logic                    result_valid_reg;
  logic [31:0]             result_data_reg;

  logic                    decode_valid;
  logic                    issue_accepted;
  logic [7:0]              rs2_bytes [4];
  logic [31:0]             mac_term;
  logic [31:0]             prod_next;
  logic                    unused_instr_bits;

  assign decode_valid = (issue_instr_i[6:0] == OPCODE) &&
                        (issue_instr_i[31:25] == 7'd0) &&
                        (issue_instr_i[14:12] <= 3'd2);

  assign issue_accept_o    = issue_valid_i & decode_valid;
  assign issue_writeback_o = issue_valid_i & decode_valid;
  assign issue_ready_o     = (state_reg == IDLE) && (issue_rs_valid_i == 2'b11) && !rst_i;
  assign issue_accepted    = issue_valid_i && issue_ready_o && decode_valid;
  assign unused_instr_bits = ^issue_instr_i[24:15];

  for (genvar gi = 0; gi < 4; gi++) begin : g_rs2_bytes
    assign rs2_bytes[gi] = rs2_reg[8*gi +: 8];
  end

  // One byte of rs2 per cycle, weighted by its position; all arithmetic wraps at 32 bits.
  assign mac_term  = (rs1_reg * {24'd0, rs2_bytes[mac_cnt_reg]}) << {mac_cnt_reg, 3'b000};
  assign prod_next = prod_reg + mac_term;

  assign busy_o         = (state_reg != IDLE);
  assign result_valid_o = result_valid_reg;
  assign result_we_o    = result_valid_reg;
  assign result_id_o    = result_valid_reg ? id_reg : '0;
  assign result_rd_o    = result_valid_reg ? rd_reg : '0;
  assign result_data_o  = result_data_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      rs1_reg          <= '0;
      rs2_reg          <= '0;
      prod_reg         <= '0;
      id_reg           <= '0;
      rd_reg           <= '0;
      funct3_reg       <= '0;
      mac_cnt_reg      <= '0;
      result_valid_reg <= 1'b0;
      result_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (issue_accepted) begin
            id_reg      <= issue_id_i;
            rd_reg      <= issue_instr_i[11:7];
            funct3_reg  <= issue_instr_i[14:12];
            rs1_reg     <= issue_rs1_i;
            rs2_reg     <= issue_rs2_i;
            prod_reg    <= '0;
            mac_cnt_reg <= '0;
            state_reg   <= WAIT_COMMIT;
          end
        end
        WAIT_COMMIT: begin
          if (commit_valid_i && (commit_id_i == id_reg)) begin
            state_reg <= commit_kill_i ? IDLE : EXEC;
          end
        end
        EXEC: begin
          if (funct3_reg == F3_MAC) begin
            prod_reg    <= prod_next;
            mac_cnt_reg <= mac_cnt_reg + 2'd1;
            if (mac_cnt_reg == 2'd3) begin
              acc_reg          <= acc_reg + prod_next;
              result_data_reg  <= acc_reg + prod_next;
              result_valid_reg <= 1'b1;
              state_reg        <= RESULT;
            end
          end else begin
            // CLR and RDACC both report the current ACC; only CLR zeroes it.
            result_data_reg  <= acc_reg;
            result_valid_reg <= 1'b1;
            state_reg        <= RESULT;
            if (funct3_reg == F3_CLR) begin
              acc_reg <= '0;
            end
          end
        end
        RESULT: begin
          if (result_ready_i) begin
            result_valid_reg <= 1'b0;
            result_data_reg  <= '0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Directed bench for xif_mac_coproc: an arithmetic accumulator model plus a queue of expected results
// (with the cycle each must appear) is checked against the result port on every falling edge.
module tb_xif_mac_coproc;
  localparam int IDW = 4;
  localparam logic [6:0] OP = 7'h0B;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           issue_valid_i = 1'b0;
  logic           issue_ready_o;
  logic [31:0]    issue_instr_i = '0;
  logic [IDW-1:0] issue_id_i = '0;
  logic [31:0]    issue_rs1_i = '0;
  logic [31:0]    issue_rs2_i = '0;
  logic [1:0]     issue_rs_valid_i = 2'b11;
  logic           issue_accept_o;
  logic           issue_writeback_o;
  logic           commit_valid_i = 1'b0;
  logic [IDW-1:0] commit_id_i = '0;
  logic           commit_kill_i = 1'b0;
  logic           result_valid_o;
  logic           result_ready_i = 1'b1;
  logic [IDW-1:0] result_id_o;
  logic [31:0]    result_data_o;
  logic [4:0]     result_rd_o;
  logic           result_we_o;
  logic           busy_o;

  xif_mac_coproc #(.X_ID_WIDTH(IDW), .OPCODE(OP)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int             rise;
    logic [IDW-1:0] id;
    logic [4:0]     rd;
    logic [31:0]    data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] m_acc = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Result-port checker: the front of the queue is due once its cycle has arrived.
  always @(negedge clk_i) begin : compare
    logic ev;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      ev = (exp_q.size() != 0) && (cyc >= exp_q[0].rise);
      checks++;
      if (result_valid_o !== ev) begin
        failures++;
        $display("FAIL result_valid cyc=%0d actual=%0b required=%0b", cyc, result_valid_o, ev);
      end
      checks++;
      if (ev) begin
        if (result_id_o !== exp_q[0].id || result_rd_o !== exp_q[0].rd ||
            result_data_o !== exp_q[0].data || result_we_o !== 1'b1) begin
          failures++;
          $display("FAIL result_fields cyc=%0d actual id=%0d rd=%0d data=0x%08h we=%0b required id=%0d rd=%0d data=0x%08h we=1",
                   cyc, result_id_o, result_rd_o, result_data_o, result_we_o,
                   exp_q[0].id, exp_q[0].rd, exp_q[0].data);
        end
        if (result_ready_i) exp_q.pop_front();
      end else if (result_id_o !== '0 || result_rd_o !== '0 || result_data_o !== '0 || result_we_o !== 1'b0) begin
        failures++;
        $display("FAIL result_idle cyc=%0d actual id=%0d rd=%0d data=0x%08h we=%0b required all zero",
                 cyc, result_id_o, result_rd_o, result_data_o, result_we_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
    return {f7, 5'd0, 5'd0, f3, rd, op};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                       input logic [31:0] a, input logic [31:0] b);
    logic exp_ok;
    exp_ok = (instr[6:0] == OP) && (instr[31:25] == 7'd0) && (instr[14:12] < 3'd3);
    step();
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_id_i    = id;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
    #1;
    chk("issue_ready", issue_ready_o, 1);
    chk("issue_accept", issue_accept_o, exp_ok);
    chk("issue_writeback", issue_writeback_o, exp_ok);
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [IDW-1:0] id, input logic kill, output int c);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    c = cyc;
    step();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [IDW-1:0] id, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, output int c);
    logic [31:0] data;
    issue(mk_instr(7'd0, f3, rd, OP), id, a, b);
    data = m_acc;
    if (f3 == 3'd0) begin
      m_acc = m_acc + a * b;
      data  = m_acc;
    end else if (f3 == 3'd1) begin
      m_acc = '0;
    end
    commit(id, 1'b0, c);
    exp_q.push_back('{rise: c + ((f3 == 3'd0) ? 5 : 2), id: id, rd: rd, data: data});
  endtask

  task automatic wait_valid_at(input int c, input int lat, input logic [31:0] data, input string name);
    while (cyc < c + lat - 1) step();
    chk({name, "_pre_valid"}, result_valid_o, 0);
    step();
    chk({name, "_valid"}, result_valid_o, 1);
    chk({name, "_data"}, result_data_o, data);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL result_timeout cyc=%0d actual pending=%0d required pending=0", cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    logic [31:0] bad_instr [4];
    bad_instr[0] = mk_instr(7'd0, 3'd3, 5'd1, OP);
    bad_instr[1] = mk_instr(7'd0, 3'd7, 5'd1, OP);
    bad_instr[2] = mk_instr(7'h01, 3'd0, 5'd1, OP);
    bad_instr[3] = mk_instr(7'd0, 3'd0, 5'd1, 7'h33);

    // Reset state
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_result_data", result_data_o, 0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_issue_ready", issue_ready_o, 1);

    // MAC 3*5 from ACC=0, then 0x10000*0x10000 which wraps to 0
    run_op(3'd0, 4'd1, 5'd5, 32'd3, 32'd5, c);
    wait_valid_at(c, 5, 32'd15, "mac1");
    chk("mac1_we", result_we_o, 1);
    chk("mac1_id", result_id_o, 1);
    chk("mac1_rd", result_rd_o, 5);
    chk("mac1_busy", busy_o, 1);
    wait_done();
    run_op(3'd0, 4'd2, 5'd6, 32'h10000, 32'h10000, c);
    wait_valid_at(c, 5, 32'd15, "mac2_wrap");
    wait_done();

    // Non-matching commit ignored, matching kill drops the MAC
    issue(mk_instr(7'd0, 3'd0, 5'd7, OP), 4'd2, 32'd7, 32'd9);
    chk("kill_busy_wait", busy_o, 1);
    commit(4'd1, 1'b0, c);
    chk("kill_ignored_commit_busy", busy_o, 1);
    commit(4'd2, 1'b1, c);
    chk("kill_busy_after", busy_o, 0);
    chk("kill_issue_ready", issue_ready_o, 1);
    repeat (6) step();
    run_op(3'd2, 4'd3, 5'd8, 32'd0, 32'd0, c);
    wait_valid_at(c, 2, 32'd15, "rdacc_after_kill");
    wait_done();

    // Invalid encodings are rejected; missing operands block issue
    for (int i = 0; i < 4; i++) begin
      issue(bad_instr[i], 4'd4, 32'd1, 32'd1);
      chk("bad_stay_idle", busy_o, 0);
      chk("bad_ready_again", issue_ready_o, 1);
    end
    issue_rs_valid_i = 2'b01;
    issue_valid_i = 1'b1;
    issue_instr_i = mk_instr(7'd0, 3'd2, 5'd1, OP);
    #1;
    chk("rs_valid01_ready", issue_ready_o, 0);
    step();
    chk("rs_valid01_idle", busy_o, 0);
    issue_rs_valid_i = 2'b10;
    #1;
    chk("rs_valid10_ready", issue_ready_o, 0);
    step();
    chk("rs_valid10_idle", busy_o, 0);
    issue_valid_i = 1'b0;
    issue_rs_valid_i = 2'b11;

    // CLR from 15, load 0x1234, then CLR and RDACC
    run_op(3'd1, 4'd5, 5'd10, 32'd0, 32'd0, c);
    wait_valid_at(c, 2, 32'd15, "clr_15");
    wait_done();
    run_op(3'd0, 4'd6, 5'd11, 32'h1234, 32'd1, c);
    wait_valid_at(c, 5, 32'h1234, "mac_1234");
    wait_done();
    run_op(3'd1, 4'd7, 5'd12, 32'd0, 32'd0, c);
    wait_valid_at(c, 2, 32'h1234, "clr_1234");
    wait_done();
    run_op(3'd2, 4'd8, 5'd13, 32'd0, 32'd0, c);
    wait_valid_at(c, 2, 32'd0, "rdacc_zero");
    wait_done();

    // Backpressure: result held stable while result_ready_i is low
    run_op(3'd0, 4'd9, 5'd14, 32'h21, 32'd3, c);
    wait_valid_at(c, 5, 32'h63, "mac_63");
    wait_done();
    result_ready_i = 1'b0;
    run_op(3'd2, 4'd10, 5'd15, 32'd0, 32'd0, c);
    wait_valid_at(c, 2, 32'h63, "hold0");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", result_valid_o, 1);
      chk("hold_data", result_data_o, 32'h63);
      chk("hold_id", result_id_o, 10);
      chk("hold_rd", result_rd_o, 15);
      chk("hold_issue_ready", issue_ready_o, 0);
    end
    result_ready_i = 1'b1;
    wait_done();

    // Reset during the second MAC EXEC cycle abandons it and clears ACC
    run_op(3'd0, 4'd11, 5'd16, 32'h100, 32'h100, c);
    while (cyc < c + 2) step();
    rst_i = 1'b1;
    m_acc = '0;
    step();
    rst_i = 1'b0;
    #1;
    chk("rst_exec_ready", issue_ready_o, 1);
    chk("rst_exec_busy", busy_o, 0);
    chk("rst_exec_valid", result_valid_o, 0);
    step();
    chk("rst_exec_ready_next", issue_ready_o, 1);
    repeat (6) step();
    run_op(3'd2, 4'd12, 5'd17, 32'd0, 32'd0, c);
    wait_valid_at(c, 2, 32'd0, "rdacc_after_rst");
    wait_done();

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
